pu_riscv_memory_queue: RTL and testbench
========================================

Name: pu_riscv_memory_queue

Overview:
- Parametrised successor to the single-register memory stage. Sits between EX and WB in the pu_riscv core.
- Holds up to DEPTH in-flight memory-stage entries. Each entry carries pc, instr, exception, result and data-memory address.
- Lets EX keep issuing while WB stalls. Adds occupancy reporting, backpressure to EX and drop-after-exception behaviour; the old stage had none of these.

Parameters:
- XLEN, 64, data/address width.
- ILEN, 64, instruction field width.
- EXCEPTION_SIZE, 16, exception vector width.
- PC_INIT, 'h8000_0000, reset value of mem_pc.
- DEPTH, 4, number of entries; power of two, >= 2.
- INSTR_NOP, 'h13, instruction driven on mem_instr when no entry is valid.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush from state/branch unit
- wb_stall  in  1  WB cannot accept head entry this cycle
- ex_pc  in  XLEN  EX pc
- ex_instr  in  ILEN  EX instruction
- ex_bubble  in  1  EX slot empty (1) or valid (0)
- ex_exception  in  EXCEPTION_SIZE  EX exception vector
- ex_r  in  XLEN  EX result
- dmem_adr  in  XLEN  data memory address of EX access
- ex_stall  out  1  queue full; EX must hold
- mem_pc  out  XLEN  head pc
- mem_instr  out  ILEN  head instruction
- mem_bubble  out  1  no valid head entry
- mem_exception  out  EXCEPTION_SIZE  head exception vector
- mem_r  out  XLEN  head result
- mem_memadr  out  XLEN  head memory address
- mem_count  out  $clog2(DEPTH+1)  valid entries
- exc_pending  out  1  excepting entry accepted, younger entries being dropped

Behaviour:
- Reset (async, rstn=0):
  - count=0, read/write pointers=0, exc_pending=0.
  - mem_pc=PC_INIT, mem_bubble=1, mem_instr=INSTR_NOP, mem_exception=0, mem_r=0, mem_memadr=0, ex_stall=0.
  - Reset mid-operation discards all entries immediately.
- Storage: circular buffer of DEPTH registers. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Outputs:
  - All mem_* outputs are driven from the head register (no EX-to-MEM combinational path).
  - Latency: an entry pushed in cycle N appears on mem_* in cycle N+1 when the queue was empty.
- ex_stall = (count==DEPTH). Registered state only; it does not depend on wb_stall. A push into a full queue therefore never occurs.
- Accept: ex_bubble=0 & ex_stall=0 & flush=0.
- Push: accept & exc_pending=0.
- Drop: accept & exc_pending=1. The entry is discarded, ex_stall stays 0 and count is unchanged.
- Bubbles (ex_bubble=1) are never stored.
- exc_pending sets on a push with |ex_exception=1 and clears only on flush or reset.
- Pop: count>0 & wb_stall=0 & flush=0. The head pointer advances.
- Empty queue (count=0):
  - mem_bubble=1, mem_instr=INSTR_NOP, mem_exception=0.
  - mem_pc holds the pc of the last popped entry (PC_INIT after reset).
  - mem_r and mem_memadr hold their last values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty queue with wb_stall=0 does not pop in the same cycle; the entry is visible first.
- flush=1 has priority over everything:
  - Next cycle count=0, mem_bubble=1, exc_pending=0.
  - Pointers reset to 0; the same-cycle EX entry is ignored.
  - mem_pc holds.
- mem_count equals count and is updated synchronously.

Test Plan:
- Reset: rstn=0 mid-run with 3 entries queued -> immediately mem_bubble=1, mem_pc='h8000_0000, mem_count=0, ex_stall=0, exc_pending=0.
- Single pass: push pc='h8000_0004, instr='h00a00093, r=10 with wb_stall=0 -> next cycle mem_pc='h8000_0004, mem_r=10, mem_bubble=0; cycle after, mem_bubble=1 and mem_pc still 'h8000_0004.
- Fill and wrap: wb_stall=1, push 4 entries (pc 'h100,'h104,'h108,'h10c) -> mem_count=4, ex_stall=1. Release wb_stall while pushing 'h110 -> output order 'h100..'h110, no loss.
- Bubble compression: alternate ex_bubble 0/1 for 6 cycles, wb_stall=1 -> mem_count=3.
- Exception drop: push pc 'h200 with ex_exception[2]=1, then 'h204,'h208 -> exc_pending=1, mem_count=1, only 'h200 emerges. After flush, exc_pending=0 and a push of 'h300 is accepted.
- Flush priority: 2 entries queued, then flush=1 together with a push and wb_stall=0 -> next cycle mem_count=0, mem_bubble=1, no entry pops and the pushed entry is absent.

Source files
------------

// File: rtl/pu_riscv_memory_queue.sv
// pu_riscv_memory_queue
//
// Memory stage between EX and WB. It holds up to DEPTH in-flight entries in a
// circular buffer, so EX can keep issuing while WB stalls. Each entry carries
// pc, instruction, exception vector, result and data-memory address.
//
// Ports
//   clk, rstn        core clock, asynchronous active-low reset
//   flush            pipeline flush; empties the queue and clears exc_pending
//   wb_stall         WB cannot take the head entry this cycle
//   ex_*, dmem_adr   incoming EX slot (ex_bubble=1 means the slot is empty)
//   ex_stall         queue full; EX must hold its entry
//   mem_*            head entry (registered state only, no path from EX inputs)
//   mem_count        number of valid entries
//   exc_pending      an excepting entry was accepted; younger entries are dropped
//
// When the queue is empty, mem_pc, mem_r and mem_memadr keep the last values
// shown on the outputs. mem_bubble is 1, mem_instr is INSTR_NOP and
// mem_exception is 0.

module pu_riscv_memory_queue #(
  parameter int unsigned             XLEN           = 64,
  parameter int unsigned             ILEN           = 64,
  parameter int unsigned             EXCEPTION_SIZE = 16,
  parameter logic [XLEN-1:0]         PC_INIT        = 'h8000_0000,
  parameter int unsigned             DEPTH          = 4,
  parameter logic [ILEN-1:0]         INSTR_NOP      = 'h13
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         wb_stall,
  input  logic [XLEN-1:0]              ex_pc,
  input  logic [ILEN-1:0]              ex_instr,
  input  logic                         ex_bubble,
  input  logic [EXCEPTION_SIZE-1:0]    ex_exception,
  input  logic [XLEN-1:0]              ex_r,
  input  logic [XLEN-1:0]              dmem_adr,
  output logic                         ex_stall,
  output logic [XLEN-1:0]              mem_pc,
  output logic [ILEN-1:0]              mem_instr,
  output logic                         mem_bubble,
  output logic [EXCEPTION_SIZE-1:0]    mem_exception,
  output logic [XLEN-1:0]              mem_r,
  output logic [XLEN-1:0]              mem_memadr,
  output logic [$clog2(DEPTH+1)-1:0]   mem_count,
  output logic                         exc_pending
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  // Entry storage; only entries between rd_ptr and wr_ptr are ever read
  logic [XLEN-1:0]           pc_q   [DEPTH];
  logic [ILEN-1:0]           instr_q[DEPTH];
  logic [EXCEPTION_SIZE-1:0] exc_q  [DEPTH];
  logic [XLEN-1:0]           r_q    [DEPTH];
  logic [XLEN-1:0]           adr_q  [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            exc_pending_q, exc_pending_d;

  // Values shown while the queue is empty
  logic [XLEN-1:0] hold_pc_q, hold_r_q, hold_adr_q;

  logic full, empty, accept, push, pop;

  always_comb begin
    full   = (count_q == CntW'(DEPTH));
    empty  = (count_q == '0);
    accept = ~ex_bubble & ~full & ~flush;
    // While an exception is pending, accepted entries are silently discarded
    push   = accept & ~exc_pending_q;
    pop    = ~empty & ~wb_stall & ~flush;
  end

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    exc_pending_d = exc_pending_q;

    if (flush) begin
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      exc_pending_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (push && (|ex_exception)) exc_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      exc_pending_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      exc_pending_q <= exc_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]    <= ex_pc;
      instr_q[wr_ptr_q] <= ex_instr;
      exc_q[wr_ptr_q]   <= ex_exception;
      r_q[wr_ptr_q]     <= ex_r;
      adr_q[wr_ptr_q]   <= dmem_adr;
    end
  end

  // Track the visible head so the outputs hold their last value once the
  // queue drains, whether through pops or a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_pc_q  <= PC_INIT;
      hold_r_q   <= '0;
      hold_adr_q <= '0;
    end else if (!empty) begin
      hold_pc_q  <= pc_q[rd_ptr_q];
      hold_r_q   <= r_q[rd_ptr_q];
      hold_adr_q <= adr_q[rd_ptr_q];
    end
  end

  always_comb begin
    ex_stall    = full;
    mem_count   = count_q;
    exc_pending = exc_pending_q;
    if (empty) begin
      mem_pc        = hold_pc_q;
      mem_instr     = INSTR_NOP;
      mem_bubble    = 1'b1;
      mem_exception = '0;
      mem_r         = hold_r_q;
      mem_memadr    = hold_adr_q;
    end else begin
      mem_pc        = pc_q[rd_ptr_q];
      mem_instr     = instr_q[rd_ptr_q];
      mem_bubble    = 1'b0;
      mem_exception = exc_q[rd_ptr_q];
      mem_r         = r_q[rd_ptr_q];
      mem_memadr    = adr_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_pu_riscv_memory_queue.sv
// Directed testbench for pu_riscv_memory_queue. Inputs change 1 ns after each
// rising edge and outputs are checked in the same window, before the next edge.

module tb_pu_riscv_memory_queue;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          wb_stall;
  logic [63:0]   ex_pc;
  logic [63:0]   ex_instr;
  logic          ex_bubble;
  logic [15:0]   ex_exception;
  logic [63:0]   ex_r;
  logic [63:0]   dmem_adr;
  logic          ex_stall;
  logic [63:0]   mem_pc;
  logic [63:0]   mem_instr;
  logic          mem_bubble;
  logic [15:0]   mem_exception;
  logic [63:0]   mem_r;
  logic [63:0]   mem_memadr;
  logic [2:0]    mem_count;
  logic          exc_pending;

  int checks = 0;
  int errors = 0;

  pu_riscv_memory_queue dut (
    .clk           (clk),
    .rstn          (rstn),
    .flush         (flush),
    .wb_stall      (wb_stall),
    .ex_pc         (ex_pc),
    .ex_instr      (ex_instr),
    .ex_bubble     (ex_bubble),
    .ex_exception  (ex_exception),
    .ex_r          (ex_r),
    .dmem_adr      (dmem_adr),
    .ex_stall      (ex_stall),
    .mem_pc        (mem_pc),
    .mem_instr     (mem_instr),
    .mem_bubble    (mem_bubble),
    .mem_exception (mem_exception),
    .mem_r         (mem_r),
    .mem_memadr    (mem_memadr),
    .mem_count     (mem_count),
    .exc_pending   (exc_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [63:0] instr, input logic [63:0] r,
                       input logic [63:0] adr, input logic [15:0] exc);
    ex_bubble    = 1'b0;
    ex_pc        = pc;
    ex_instr     = instr;
    ex_r         = r;
    dmem_adr     = adr;
    ex_exception = exc;
  endtask

  task automatic idle();
    ex_bubble    = 1'b1;
    ex_pc        = '0;
    ex_instr     = '0;
    ex_r         = '0;
    dmem_adr     = '0;
    ex_exception = '0;
  endtask

  initial begin
    rstn     = 1'b0;
    flush    = 1'b0;
    wb_stall = 1'b0;
    idle();
    tick();
    tick();

    // Reset state
    check("rst_bubble", {63'd0, mem_bubble}, 64'd1);
    check("rst_pc", mem_pc, 64'h8000_0000);
    check("rst_instr", mem_instr, 64'h13);
    check("rst_exc", {48'd0, mem_exception}, 64'd0);
    check("rst_count", {61'd0, mem_count}, 64'd0);
    check("rst_stall", {63'd0, ex_stall}, 64'd0);
    check("rst_excp", {63'd0, exc_pending}, 64'd0);
    rstn = 1'b1;
    tick();

    // Single pass: visible one cycle after push, popped the cycle after
    drive(64'h8000_0004, 64'h00a0_0093, 64'd10, 64'h40, 16'h0);
    tick();
    idle();
    check("sp_pc", mem_pc, 64'h8000_0004);
    check("sp_r", mem_r, 64'd10);
    check("sp_adr", mem_memadr, 64'h40);
    check("sp_instr", mem_instr, 64'h00a0_0093);
    check("sp_bubble", {63'd0, mem_bubble}, 64'd0);
    tick();
    check("sp_bubble2", {63'd0, mem_bubble}, 64'd1);
    check("sp_pc_hold", mem_pc, 64'h8000_0004);
    check("sp_r_hold", mem_r, 64'd10);
    check("sp_instr_nop", mem_instr, 64'h13);
    check("sp_count", {61'd0, mem_count}, 64'd0);

    // Fill and wrap
    wb_stall = 1'b1;
    drive(64'h100, 64'h1, 64'd1, 64'h0, 16'h0); tick();
    drive(64'h104, 64'h2, 64'd2, 64'h0, 16'h0); tick();
    drive(64'h108, 64'h3, 64'd3, 64'h0, 16'h0); tick();
    drive(64'h10c, 64'h4, 64'd4, 64'h0, 16'h0); tick();
    check("fill_count", {61'd0, mem_count}, 64'd4);
    check("fill_stall", {63'd0, ex_stall}, 64'd1);
    check("fill_head", mem_pc, 64'h100);
    // 'h110 waits one cycle on ex_stall, then goes in alongside a pop
    drive(64'h110, 64'h5, 64'd5, 64'h0, 16'h0);
    wb_stall = 1'b0;
    tick();
    check("wrap_head1", mem_pc, 64'h104);
    check("wrap_count1", {61'd0, mem_count}, 64'd3);
    check("wrap_stall1", {63'd0, ex_stall}, 64'd0);
    tick();
    idle();
    check("wrap_head2", mem_pc, 64'h108);
    check("wrap_count2", {61'd0, mem_count}, 64'd3);
    tick();
    check("wrap_head3", mem_pc, 64'h10c);
    tick();
    check("wrap_head4", mem_pc, 64'h110);
    check("wrap_r4", mem_r, 64'd5);
    check("wrap_count4", {61'd0, mem_count}, 64'd1);
    tick();
    check("wrap_empty", {63'd0, mem_bubble}, 64'd1);
    check("wrap_pc_hold", mem_pc, 64'h110);

    // Bubble compression
    wb_stall = 1'b1;
    drive(64'h400, 64'h6, 64'd6, 64'h0, 16'h0); tick();
    idle(); tick();
    drive(64'h404, 64'h7, 64'd7, 64'h0, 16'h0); tick();
    idle(); tick();
    drive(64'h408, 64'h8, 64'd8, 64'h0, 16'h0); tick();
    idle(); tick();
    check("bub_count", {61'd0, mem_count}, 64'd3);
    check("bub_head", mem_pc, 64'h400);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("bub_flush_count", {61'd0, mem_count}, 64'd0);
    check("bub_flush_bubble", {63'd0, mem_bubble}, 64'd1);
    check("bub_flush_pc", mem_pc, 64'h400);

    // Exception drop
    drive(64'h200, 64'h9, 64'd9, 64'h0, 16'h0004); tick();
    check("exc_pending1", {63'd0, exc_pending}, 64'd1);
    drive(64'h204, 64'ha, 64'd10, 64'h0, 16'h0); tick();
    drive(64'h208, 64'hb, 64'd11, 64'h0, 16'h0); tick();
    idle();
    check("exc_count", {61'd0, mem_count}, 64'd1);
    check("exc_pending2", {63'd0, exc_pending}, 64'd1);
    check("exc_stall", {63'd0, ex_stall}, 64'd0);
    check("exc_head", mem_pc, 64'h200);
    check("exc_vec", {48'd0, mem_exception}, 64'h4);
    wb_stall = 1'b0;
    tick();
    check("exc_drained", {63'd0, mem_bubble}, 64'd1);
    check("exc_drained_vec", {48'd0, mem_exception}, 64'd0);
    check("exc_drained_pc", mem_pc, 64'h200);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("exc_cleared", {63'd0, exc_pending}, 64'd0);
    drive(64'h300, 64'hc, 64'd12, 64'h0, 16'h0); tick();
    idle();
    check("exc_after_pc", mem_pc, 64'h300);
    check("exc_after_bubble", {63'd0, mem_bubble}, 64'd0);
    tick();

    // Flush priority over push and pop
    wb_stall = 1'b1;
    drive(64'h500, 64'hd, 64'd13, 64'h0, 16'h0); tick();
    drive(64'h504, 64'he, 64'd14, 64'h0, 16'h0); tick();
    check("fp_count", {61'd0, mem_count}, 64'd2);
    drive(64'h508, 64'hf, 64'd15, 64'h0, 16'h0);
    wb_stall = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fp_count0", {61'd0, mem_count}, 64'd0);
    check("fp_bubble", {63'd0, mem_bubble}, 64'd1);
    check("fp_pc_hold", mem_pc, 64'h500);
    tick();
    check("fp_absent", {61'd0, mem_count}, 64'd0);

    // Asynchronous reset mid-run
    wb_stall = 1'b1;
    drive(64'h600, 64'h10, 64'd16, 64'h0, 16'h0); tick();
    drive(64'h604, 64'h11, 64'd17, 64'h0, 16'h0); tick();
    drive(64'h608, 64'h12, 64'd18, 64'h0, 16'h0); tick();
    idle();
    check("mr_count3", {61'd0, mem_count}, 64'd3);
    rstn = 1'b0;
    #1;
    check("mr_bubble", {63'd0, mem_bubble}, 64'd1);
    check("mr_pc", mem_pc, 64'h8000_0000);
    check("mr_count", {61'd0, mem_count}, 64'd0);
    check("mr_stall", {63'd0, ex_stall}, 64'd0);
    check("mr_excp", {63'd0, exc_pending}, 64'd0);
    check("mr_r", mem_r, 64'd0);
    tick();
    rstn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
